// File: rtl/serial_mux_adder_if.sv
// Handshake/bus bundle for serial_mux_adder.
//   master : drives start/sub/a/b, observes busy/done/result/cout/ovf
//   slave  : the adder itself
// Signals:
//   start  request, sampled only when the adder is not busy
//   sub    0 = a+b, 1 = a-b, sampled with start
//   a, b   operands, sampled with start
//   busy   high while bits are being processed
//   done   one-cycle completion pulse
//   result registered sum/difference
//   cout   carry out of MSB (sub: 1 = no borrow)
//   ovf    signed overflow
interface serial_mux_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             ovf;

  modport master (
    output start, sub, a, b,
    input  busy, done, result, cout, ovf
  );

  modport slave (
    input  start, sub, a, b,
    output busy, done, result, cout, ovf
  );
endinterface

// File: rtl/serial_mux_adder.sv
// Bit-serial adder/subtractor. The full-adder function is an 8:1 mux
// (two constant truth tables) indexed by {a_bit, b_bit, carry}; one bit is
// processed per clock, LSB first, and the result is presented registered
// together with carry-out and signed overflow.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    serial_mux_adder_if.slave (start/sub/a/b in, busy/done/result/cout/ovf out)
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start
// SHIFT | one operand bit per cycle through the mux full adder
// DONE  | single-cycle done pulse; start here relaunches without a gap
module serial_mux_adder #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  serial_mux_adder_if.slave  bus
);

  localparam int CW = $clog2(WIDTH) + 1;

  // Truth tables indexed by {a_bit, b_bit, carry_in}.
  localparam logic [7:0] SUM_TBL   = 8'b1001_0110;
  localparam logic [7:0] CARRY_TBL = 8'b1110_1000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;

  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] s_sr;
  logic [WIDTH-1:0] s_sr_nxt;
  logic [WIDTH-1:0] result_q;
  logic             carry;
  logic             cout_q;
  logic             ovf_q;
  logic [CW-1:0]    cnt;

  logic [2:0]       idx;
  logic             sum_bit;
  logic             carry_nxt;
  logic             c_msb_in;
  logic             last_bit;
  logic             load;

  assign idx       = {a_sr[0], b_sr[0], carry};
  assign sum_bit   = SUM_TBL[idx];
  assign carry_nxt = CARRY_TBL[idx];
  assign last_bit  = (state == SHIFT) && (cnt == CW'(WIDTH - 1));
  assign load      = (state != SHIFT) && bus.start;

  // During the MSB cycle the carry flop holds the carry into the MSB.
  assign c_msb_in  = carry;

  // Sum bits enter at the top so that after WIDTH shifts bit 0 sits at the LSB.
  assign s_sr_nxt  = {sum_bit, {(WIDTH-1){1'b0}}} | (s_sr >> 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = SHIFT;
      SHIFT:   if (last_bit)  state_nxt = DONE;
      DONE:    state_nxt = bus.start ? SHIFT : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr     <= '0;
      b_sr     <= '0;
      s_sr     <= '0;
      carry    <= 1'b0;
      cnt      <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else if (load) begin
      // Subtraction is a + ~b + 1: invert b and preload the carry.
      a_sr  <= bus.a;
      b_sr  <= bus.sub ? ~bus.b : bus.b;
      carry <= bus.sub;
      cnt   <= '0;
      s_sr  <= '0;
    end else if (state == SHIFT) begin
      a_sr  <= a_sr >> 1;
      b_sr  <= b_sr >> 1;
      s_sr  <= s_sr_nxt;
      carry <= carry_nxt;
      cnt   <= cnt + CW'(1);
      if (last_bit) begin
        result_q <= s_sr_nxt;
        cout_q   <= carry_nxt;
        ovf_q    <= c_msb_in ^ carry_nxt;
      end
    end
  end

  assign bus.busy   = (state == SHIFT);
  assign bus.done   = (state == DONE);
  assign bus.result = result_q;
  assign bus.cout   = cout_q;
  assign bus.ovf    = ovf_q;

endmodule
